mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-ported unified memory between the core's instruction-fetch path and its load/store path. It accepts one request from each side, grants one at a time to the memory port, and holds the access until the memory acknowledges. It produces a stall to freeze the PC and register writeback while either side waits. It sits between the core (fetch address, ALU address, byte enables, store data) and the memory macro, replacing the split instruction/data memories.

## Interface
Parameters:
- MAX_D_STREAK, default 4: consecutive data grants allowed while a fetch is pending. Range 1–15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high with if_addr stable until if_ready.
- if_addr  input  32  fetch byte address; word aligned.
- if_rdata  output  32  fetch data; valid only while if_ready=1.
- if_ready  output  1  one-cycle completion pulse for the fetch.
- d_req  input  1  data request; held high with payload stable until d_ready.
- d_we  input  4  byte write enables; 0000 means load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data, already lane-aligned.
- d_rdata  output  32  load data; valid only while d_ready=1.
- d_ready  output  1  one-cycle completion pulse for the data access.
- m_req  output  1  memory request; held until m_ack.
- m_we  output  4  memory byte enables.
- m_addr  output  32  memory address.
- m_wdata  output  32  memory write data.
- m_rdata  input  32  memory read data; valid with m_ack.
- m_ack  input  1  one-cycle completion from memory. May assert in the first m_req cycle.
- core_stall  output  1  high while any active request is not yet completed.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE with no request: stay in IDLE.
- IDLE with a request: go to BUSY_IF or BUSY_D.
  - m_we, m_addr and m_wdata are registered on the transition.
  - For a fetch, m_we is 0000 and m_wdata is 0.
- BUSY_x:
  - m_req=1 and the registered payload is driven.
  - When m_ack=1, x_ready=1 and x_rdata=m_rdata in the same cycle (combinational), and the next state is IDLE.
  - Requests arriving during BUSY are only evaluated in IDLE.
- Arbitration, decided in IDLE only:
  - Only one request: grant it.
  - Both requests: grant data, unless streak == MAX_D_STREAK, in which case grant fetch.
- streak counter (4 bits):
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant.
  - Holds on a data grant with if_req=0.
  - Saturates at MAX_D_STREAK.
- core_stall = (if_req & ~if_ready) | (d_req & ~d_ready). Purely combinational.
- Stores: d_rdata still mirrors m_rdata on d_ready, and the core ignores it.
- A requester holding req high in the cycle after its ready pulse is issuing a new request.

## Timing
- Reset values:
  - State IDLE, streak 0.
  - m_req=0, m_we=0000, m_addr=0, m_wdata=0.
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - core_stall follows its inputs and is 0 when neither request is asserted.
- Latency from req sampled at edge N:
  - m_req rises after edge N.
  - With zero-wait memory (m_ack in the first BUSY cycle), ready occurs in the cycle after edge N and the arbiter is back in IDLE after edge N+1.
  - Minimum issue interval is 2 cycles per access.
- Back-to-back accesses from both sides alternate IDLE/BUSY states. The pending side sees core_stall continuously.
- Reset asserted mid-access:
  - m_req drops immediately (asynchronously) and no ready pulse is generated.
  - The memory must discard the abandoned access.
  - Requesters re-issue after reset.
- m_ack in IDLE is ignored (protocol error). No ready pulse is generated and no state changes.
- if_ready and d_ready are never high in the same cycle.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_D);
  - the grant encoding;
  - the WE_LOAD = 4'b0000 constant.
- The core's load-stall and NOP-insertion logic consumes core_stall and does not duplicate it.
- Single module. No sub-module: the streak counter is inline, being under 15 lines.

## Test plan
- Fetch alone, zero-wait memory: if_req with if_addr=0x100, m_ack in the first BUSY cycle, m_rdata=0x00000013.
  - Expect if_ready for 1 cycle with if_rdata=0x13, m_we=0000.
  - Expect core_stall high in the request cycle and low in the ready cycle.
- Store: d_req, d_we=0011, d_addr=0x2000, d_wdata=0x0000BEEF, memory 3-cycle latency.
  - Expect m_req held 3 cycles with a stable payload.
  - Expect d_ready on the ack cycle only.
- Simultaneous requests, MAX_D_STREAK=2, d_req always high with d_ready honored:
  - Expect grant order D, D, IF, D, D, IF.
  - Expect streak to read 0 after each IF grant.
- Fetch pending while a data access is BUSY:
  - Expect the fetch to be granted in the next IDLE.
  - Expect if_ready no earlier than 2 cycles after d_ready.
- Reset pulse during BUSY_D with 5-cycle memory latency:
  - Expect m_req=0 and state IDLE immediately.
  - Expect no d_ready.
  - After release, the re-issued request completes normally.
- Spurious m_ack in IDLE: expect no ready pulse and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant
// encoding and the load byte-enable constant.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    localparam logic [3:0] WE_LOAD = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// load/store, holding each access until m_ack and raising core_stall meanwhile.
//
// Handshake: a requester holds x_req with a stable payload until its one-cycle
// x_ready pulse; holding x_req high in the following cycle is a new request.
// The memory side sees m_req held with a stable payload until a one-cycle m_ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic [3:0]  m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        core_stall,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_streak
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    arb_state_t  state_q, state_d;
    grant_t      grant;
    logic [3:0]  streak_q;
    logic [3:0]  m_we_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;

    // Data wins ties until it has starved a pending fetch MAX_D_STREAK times.
    always_comb begin
        grant = GNT_NONE;
        if (state_q == IDLE) begin
            if (d_req && (!if_req || (streak_q != STREAK_MAX))) begin
                grant = GNT_D;
            end else if (if_req) begin
                grant = GNT_IF;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant == GNT_D) begin
                    state_d = BUSY_D;
                end else if (grant == GNT_IF) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (m_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_we_q    <= WE_LOAD;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
        end else if (grant == GNT_D) begin
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
        end else if (grant == GNT_IF) begin
            m_we_q    <= WE_LOAD;
            m_addr_q  <= if_addr;
            m_wdata_q <= 32'd0;
        end
    end

    // Counts data grants taken while a fetch waited; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 4'd0;
        end else if (grant == GNT_IF) begin
            streak_q <= 4'd0;
        end else if ((grant == GNT_D) && if_req && (streak_q < STREAK_MAX)) begin
            streak_q <= streak_q + 4'd1;
        end
    end

    always_comb begin
        m_req      = (state_q != IDLE);
        m_we       = m_we_q;
        m_addr     = m_addr_q;
        m_wdata    = m_wdata_q;
        if_ready   = (state_q == BUSY_IF) && m_ack;
        d_ready    = (state_q == BUSY_D) && m_ack;
        if_rdata   = if_ready ? m_rdata : 32'd0;
        d_rdata    = d_ready ? m_rdata : 32'd0;
        core_stall = (if_req && !if_ready) || (d_req && !d_ready);
        dbg_state  = state_q;
        dbg_streak = streak_q;
    end

endmodule
